// File: rtl/fmul_issue_queue_if.sv
// Handshake bundle for the fmul issue queue: operand issue side and result side.
interface fmul_issue_queue_if #(
    parameter int unsigned TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_x1;
    logic [31:0]      in_x2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_y;
    logic [TAG_W-1:0] out_tag;

    // Producer/consumer view (the environment around the queue).
    modport master (
        output in_valid, in_x1, in_x2, in_tag, out_ready,
        input  in_ready, out_valid, out_y, out_tag
    );

    // Queue view.
    modport slave (
        input  in_valid, in_x1, in_x2, in_tag, out_ready,
        output in_ready, out_valid, out_y, out_tag
    );
endinterface

// File: rtl/fmul_issue_queue.sv
// Issue/collect stage around a fixed-latency fmul: operands pass straight through to fmul,
// accepted ops are tracked by a {valid, tag} delay line, and products land in a result FIFO.
// in_ready is credit based (queued + in-flight < DEPTH) so a capture can never find the FIFO full.
module fmul_issue_queue #(
    parameter int unsigned LAT   = 2,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4,
    localparam int unsigned CW   = $clog2(DEPTH + 1),
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    fmul_issue_queue_if.slave    bus,
    output logic [31:0]          fmul_x1,
    output logic [31:0]          fmul_x2,
    input  logic [31:0]          fmul_y,
    output logic [CW-1:0]        count
);

    logic             fire;
    logic             capture;
    logic             pop;

    logic [LAT-1:0]   dl_vld_q;
    logic [TAG_W-1:0] dl_tag_q [LAT];

    logic [31:0]      mem_y_q   [DEPTH];
    logic [TAG_W-1:0] mem_tag_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    occ_q;
    logic [CW-1:0]    inflight;

    // Operands go to fmul every cycle; only accepted ops are tracked.
    assign fmul_x1 = bus.in_x1;
    assign fmul_x2 = bus.in_x2;

    assign fire    = bus.in_valid & bus.in_ready;
    assign capture = dl_vld_q[LAT-1];

    assign bus.out_valid = (occ_q != '0);
    assign pop           = bus.out_valid & bus.out_ready;
    assign bus.out_y     = mem_y_q[rd_ptr_q];
    assign bus.out_tag   = mem_tag_q[rd_ptr_q];

    // Credit: registered state only, so a pop frees a slot one cycle later.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < int'(LAT); i++) begin
            inflight = inflight + CW'(dl_vld_q[i]);
        end
        count        = occ_q + inflight;
        bus.in_ready = (count < CW'(DEPTH));
    end

    // Valid half of the delay line; cleared on reset so later fmul outputs are ignored.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            dl_vld_q <= '0;
        end else begin
            dl_vld_q[0] <= fire;
            for (int k = 1; k < int'(LAT); k++) begin
                dl_vld_q[k] <= dl_vld_q[k-1];
            end
        end
    end

    // Tag half of the delay line; meaningful only where the matching valid bit is set.
    always_ff @(posedge clk) begin
        dl_tag_q[0] <= bus.in_tag;
        for (int k = 1; k < int'(LAT); k++) begin
            dl_tag_q[k] <= dl_tag_q[k-1];
        end
    end

    // Result storage written on capture.
    always_ff @(posedge clk) begin
        if (capture) begin
            mem_y_q[wr_ptr_q]   <= fmul_y;
            mem_tag_q[wr_ptr_q] <= dl_tag_q[LAT-1];
        end
    end

    // FIFO pointers and occupancy; pointers wrap explicitly so DEPTH need not be a power of two.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (capture) begin
                wr_ptr_q <= (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            if (capture && !pop) begin
                occ_q <= occ_q + 1'b1;
            end else if (!capture && pop) begin
                occ_q <= occ_q - 1'b1;
            end
        end
    end

    // Credit accounting must make a capture into a full, non-popping FIFO impossible.
    always_ff @(posedge clk) begin
        if (rstn) begin
            assert (!(capture && !pop && (occ_q == CW'(DEPTH))));
        end
    end

endmodule

// File: tb/tb_fmul_issue_queue.sv
// Directed bench for fmul_issue_queue with a 2-stage behavioural fmul built from a product table.
module tb_fmul_issue_queue;

    localparam int unsigned LAT   = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TAG_W = 4;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    fmul_issue_queue_if #(.TAG_W(TAG_W)) bus ();

    logic [31:0]   fmul_x1;
    logic [31:0]   fmul_x2;
    logic [31:0]   fmul_y;
    logic [CW-1:0] count;

    fmul_issue_queue #(
        .LAT   (LAT),
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .bus     (bus),
        .fmul_x1 (fmul_x1),
        .fmul_x2 (fmul_x2),
        .fmul_y  (fmul_y),
        .count   (count)
    );

    // Hand-computed IEEE single products.
    logic [31:0] op_x1 [8];
    logic [31:0] op_x2 [8];
    logic [31:0] op_y  [8];
    initial begin
        op_x1 = '{32'h40000000, 32'h3FC00000, 32'hC0000000, 32'h00000000,
                  32'h3F800000, 32'h40800000, 32'h40A00000, 32'h41000000};
        op_x2 = '{32'h40400000, 32'h3FC00000, 32'h40400000, 32'h3F800000,
                  32'h3F800000, 32'h3F000000, 32'h40000000, 32'h3F000000};
        op_y  = '{32'h40C00000, 32'h40100000, 32'hC0C00000, 32'h00000000,
                  32'h3F800000, 32'h40000000, 32'h41200000, 32'h40800000};
    end

    function automatic logic [31:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        r = 32'hDEADBEEF;
        for (int i = 0; i < 8; i++) begin
            if (op_x1[i] == a && op_x2[i] == b) r = op_y[i];
        end
        return r;
    endfunction

    // Behavioural fmul: product appears LAT=2 cycles after operands are presented.
    logic [31:0] fm_s1, fm_s2;
    always @(posedge clk) begin
        fm_s1 <= fmul_ref(fmul_x1, fmul_x2);
        fm_s2 <= fm_s1;
    end
    assign fmul_y = fm_s2;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.in_valid = 1'b0;
        bus.in_x1    = 32'h0;
        bus.in_x2    = 32'h0;
        bus.in_tag   = '0;
    endtask

    task automatic drive_op(input int idx, input logic [TAG_W-1:0] tag);
        bus.in_valid = 1'b1;
        bus.in_x1    = op_x1[idx];
        bus.in_x2    = op_x2[idx];
        bus.in_tag   = tag;
    endtask

    task automatic do_reset;
        rstn          = 1'b0;
        idle();
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        #1;
        chk("reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset count", 32'(count), 32'd0);
        chk("reset in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    typedef struct {
        logic             iv;
        logic [31:0]      x1;
        logic [31:0]      x2;
        logic [TAG_W-1:0] tag;
        logic             ordy;
        logic             ov;
        logic [31:0]      y;
        logic [TAG_W-1:0] otag;
        logic             ir;
        logic [CW-1:0]    cnt;
    } vec_t;

    function automatic vec_t mk(input logic iv, input logic [31:0] x1, input logic [31:0] x2,
                                input logic [TAG_W-1:0] tag, input logic ordy, input logic ov,
                                input logic [31:0] y, input logic [TAG_W-1:0] otag,
                                input logic ir, input logic [CW-1:0] cnt);
        vec_t v;
        v.iv = iv; v.x1 = x1; v.x2 = x2; v.tag = tag; v.ordy = ordy;
        v.ov = ov; v.y = y; v.otag = otag; v.ir = ir; v.cnt = cnt;
        return v;
    endfunction

    vec_t vec [12];

    // Spurious-result and receive bookkeeping for the wrap test.
    logic [31:0]      exp_y   [$];
    logic [TAG_W-1:0] exp_tag [$];

    initial begin
        // Single op (cycles 0-4), then a 3-op back-to-back stream (cycles 5-11).
        vec[0]  = mk(1, 32'h40000000, 32'h40400000, 4'd3, 1, 0, 32'h0,        4'd0, 1, 3'd0);
        vec[1]  = mk(0, 32'h0,        32'h0,        4'd0, 1, 0, 32'h0,        4'd0, 1, 3'd1);
        vec[2]  = mk(0, 32'h0,        32'h0,        4'd0, 1, 0, 32'h0,        4'd0, 1, 3'd1);
        vec[3]  = mk(0, 32'h0,        32'h0,        4'd0, 1, 1, 32'h40C00000, 4'd3, 1, 3'd1);
        vec[4]  = mk(0, 32'h0,        32'h0,        4'd0, 1, 0, 32'h0,        4'd0, 1, 3'd0);
        vec[5]  = mk(1, 32'h3FC00000, 32'h3FC00000, 4'd1, 1, 0, 32'h0,        4'd0, 1, 3'd0);
        vec[6]  = mk(1, 32'hC0000000, 32'h40400000, 4'd2, 1, 0, 32'h0,        4'd0, 1, 3'd1);
        vec[7]  = mk(1, 32'h00000000, 32'h3F800000, 4'd3, 1, 0, 32'h0,        4'd0, 1, 3'd2);
        vec[8]  = mk(0, 32'h0,        32'h0,        4'd0, 1, 1, 32'h40100000, 4'd1, 1, 3'd3);
        vec[9]  = mk(0, 32'h0,        32'h0,        4'd0, 1, 1, 32'hC0C00000, 4'd2, 1, 3'd2);
        vec[10] = mk(0, 32'h0,        32'h0,        4'd0, 1, 1, 32'h00000000, 4'd3, 1, 3'd1);
        vec[11] = mk(0, 32'h0,        32'h0,        4'd0, 1, 0, 32'h0,        4'd0, 1, 3'd0);

        do_reset();
        for (int i = 0; i < 12; i++) begin
            next_cycle();
            bus.in_valid  = vec[i].iv;
            bus.in_x1     = vec[i].x1;
            bus.in_x2     = vec[i].x2;
            bus.in_tag    = vec[i].tag;
            bus.out_ready = vec[i].ordy;
            #1;
            chk($sformatf("vec%0d fmul_x1", i), fmul_x1, vec[i].x1);
            chk($sformatf("vec%0d fmul_x2", i), fmul_x2, vec[i].x2);
            chk($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'(vec[i].ov));
            chk($sformatf("vec%0d in_ready", i), 32'(bus.in_ready), 32'(vec[i].ir));
            chk($sformatf("vec%0d count", i), 32'(count), 32'(vec[i].cnt));
            if (vec[i].ov) begin
                chk($sformatf("vec%0d out_y", i), bus.out_y, vec[i].y);
                chk($sformatf("vec%0d out_tag", i), 32'(bus.out_tag), 32'(vec[i].otag));
            end
        end

        // Backpressure: in_valid held, out_ready low -> exactly DEPTH accepts.
        do_reset();
        for (int c = 0; c < 8; c++) begin
            next_cycle();
            drive_op(c, TAG_W'(c));
            #1;
            chk($sformatf("bp c%0d in_ready", c), 32'(bus.in_ready), (c < 4) ? 32'd1 : 32'd0);
            chk($sformatf("bp c%0d count", c), 32'(count), (c < 4) ? 32'(c) : 32'd4);
        end
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            idle();
            bus.out_ready = 1'b1;
            #1;
            chk($sformatf("bp drain%0d out_valid", k), 32'(bus.out_valid), 32'd1);
            chk($sformatf("bp drain%0d out_y", k), bus.out_y, op_y[k]);
            chk($sformatf("bp drain%0d out_tag", k), 32'(bus.out_tag), 32'(k));
            chk($sformatf("bp drain%0d in_ready", k), 32'(bus.in_ready), (k >= 1) ? 32'd1 : 32'd0);
        end
        next_cycle();
        chk("bp empty out_valid", 32'(bus.out_valid), 32'd0);
        chk("bp empty count", 32'(count), 32'd0);

        // Full occupancy with capture and pop in the same cycle.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            drive_op(4 + c, TAG_W'(4 + c));
        end
        next_cycle();
        idle();
        #1;
        chk("full c4 count", 32'(count), 32'd4);
        next_cycle();
        bus.out_ready = 1'b1;
        #1;
        chk("full c5 count", 32'(count), 32'd4);
        chk("full c5 out_y", bus.out_y, op_y[4]);
        next_cycle();
        bus.out_ready = 1'b0;
        #1;
        chk("full c6 count", 32'(count), 32'd3);
        chk("full c6 out_tag", 32'(bus.out_tag), 32'd5);
        for (int k = 5; k < 8; k++) begin
            bus.out_ready = 1'b1;
            #1;
            chk($sformatf("full drain%0d out_valid", k), 32'(bus.out_valid), 32'd1);
            chk($sformatf("full drain%0d out_y", k), bus.out_y, op_y[k]);
            chk($sformatf("full drain%0d out_tag", k), 32'(bus.out_tag), 32'(k));
            next_cycle();
        end
        chk("full empty out_valid", 32'(bus.out_valid), 32'd0);

        // Pointer wrap: 11 ops against random consumer stalls, scoreboarded in order.
        do_reset();
        begin
            int sent = 0;
            int got  = 0;
            for (int cyc = 0; cyc < 300 && got < 11; cyc++) begin
                next_cycle();
                if (sent < 11) drive_op(sent % 8, TAG_W'(sent));
                else idle();
                bus.out_ready = 1'($urandom_range(0, 1));
                #1;
                if (bus.in_valid && bus.in_ready) begin
                    exp_y.push_back(op_y[sent % 8]);
                    exp_tag.push_back(TAG_W'(sent));
                    sent++;
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_y.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL wrap spurious: got result %08h expected none", bus.out_y);
                    end else begin
                        chk($sformatf("wrap res%0d out_y", got), bus.out_y, exp_y.pop_front());
                        chk($sformatf("wrap res%0d out_tag", got), 32'(bus.out_tag),
                            32'(exp_tag.pop_front()));
                    end
                    got++;
                end
            end
            chk("wrap received", 32'(got), 32'd11);
        end
        idle();
        bus.out_ready = 1'b0;

        // Reset mid-flight: 2 queued + 2 in flight, then nothing may emerge.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            drive_op(c, TAG_W'(c));
        end
        next_cycle();
        idle();
        #1;
        chk("midrst pre count", 32'(count), 32'd4);
        rstn = 1'b0;
        next_cycle();
        rstn = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("midrst out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst count", 32'(count), 32'd0);
        chk("midrst in_ready", 32'(bus.in_ready), 32'd1);
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            chk($sformatf("midrst after%0d out_valid", k), 32'(bus.out_valid), 32'd0);
            chk($sformatf("midrst after%0d count", k), 32'(count), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000ns");
        $fatal(1);
    end

endmodule
